// File: rtl/axi2s_pkg.sv
// axi2s_pkg: AXI3 write encodings, FSM states and error flag indices for the S2A ring writer
package axi2s_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam int         ERR_OVF    = 0;
  localparam int         ERR_SLV    = 1;
  typedef enum logic [1:0] {IDLE, AW, W, B} state_e;
  function automatic logic [2:0] size_enc(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction
endpackage

// File: rtl/s2a_fifo.sv
// s2a_fifo: first-word-fall-through sample FIFO with level output and synchronous flush
module s2a_fifo #(
  parameter int DATA_W  = 32,
  parameter int FIFO_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [FIFO_AW:0]  level,
  output logic              full
);
  logic [DATA_W-1:0] mem_q [2**FIFO_AW];
  logic [FIFO_AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0]  push_inc, pop_inc;
  assign push_inc = {{FIFO_AW{1'b0}}, push};
  assign pop_inc  = {{FIFO_AW{1'b0}}, pop};
  // flush restarts both pointers but keeps a word pushed in the same cycle at slot 0
  always_comb begin
    wr_d = flush ? push_inc : wr_q + push_inc;
    rd_d = flush ? '0 : rd_q + pop_inc;
  end
  // pointer registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  // storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk)
    if (push) mem_q[flush ? {FIFO_AW{1'b0}} : wr_q[FIFO_AW-1:0]] <= din;
  assign dout  = mem_q[rd_q[FIFO_AW-1:0]];
  assign level = wr_q - rd_q;
  assign full  = level[FIFO_AW];
endmodule

// File: rtl/s2a_ring_writer.sv
// s2a_ring_writer: buffers a sample stream and writes it as fixed-length AXI3 INCR bursts into an OCM ring
module s2a_ring_writer
  import axi2s_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          BURST_LEN = 16,
  parameter logic [31:0] ocm_haddr = 32'hfffc0000,
  parameter int          ocm_width = 16,
  parameter int          FIFO_AW   = 5,
  parameter logic [5:0]  AXI_ID    = 6'h3f
) (
  input  logic                AXI_clk,
  input  logic                rst,
  input  logic                sync,
  input  logic [DATA_W-1:0]   Sin,
  input  logic                Ien,
  output logic [31:0]         AXI_awaddr,
  output logic [3:0]          AXI_awlen,
  output logic [2:0]          AXI_awsize,
  output logic [1:0]          AXI_awburst,
  output logic [5:0]          AXI_awid,
  output logic [1:0]          AXI_awlock,
  output logic [3:0]          AXI_awcache,
  output logic [2:0]          AXI_awprot,
  output logic [3:0]          AXI_awqos,
  output logic                AXI_awvalid,
  input  logic                AXI_awready,
  output logic [DATA_W-1:0]   AXI_wdata,
  output logic [DATA_W/8-1:0] AXI_wstrb,
  output logic [5:0]          AXI_wid,
  output logic                AXI_wlast,
  output logic                AXI_wvalid,
  input  logic                AXI_wready,
  input  logic [5:0]          AXI_bid,
  input  logic [1:0]          AXI_bresp,
  input  logic                AXI_bvalid,
  output logic                AXI_bready,
  output logic [31:0]         s2a_cnt,
  output logic [1:0]          s2a_err,
  output logic                s2a_busy
);
  localparam int                   BYTES       = BURST_LEN * DATA_W / 8;
  localparam logic [ocm_width-1:0] BURST_BYTES = BYTES[ocm_width-1:0];
  localparam logic [FIFO_AW:0]     LVL_TH      = BURST_LEN[FIFO_AW:0];
  localparam logic [3:0]           LAST_BEAT   = 4'(BURST_LEN - 1);

  state_e               state_q, state_d;
  logic [ocm_width-1:0] offset_q, offset_d;
  logic [3:0]           beat_q, beat_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [1:0]           err_q, err_d;
  logic                 pend_q, pend_d;
  logic [FIFO_AW:0]     level;
  logic                 full, push, pop, flush, discard, ovf, b_hs, last_beat;
  logic                 bid_unused;

  s2a_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_fifo (
    .clk(AXI_clk), .rst(rst), .flush(flush), .push(push), .pop(pop),
    .din(Sin), .dout(AXI_wdata), .level(level), .full(full)
  );

  assign last_beat = beat_q == LAST_BEAT;
  assign pop       = state_q == W && AXI_wready;
  assign b_hs      = state_q == B && AXI_bvalid;
  assign flush     = (state_q == IDLE && sync) || (b_hs && (pend_q || sync));
  assign discard   = pend_q || (sync && state_q != IDLE);
  assign push      = Ien && !discard && (flush || !full);
  assign ovf       = Ien && !discard && !flush && full;

  // burst sequencing, ring advance and status; a frame restart overrides the B-phase update
  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    offset_d         = offset_q;
    cnt_d            = cnt_q;
    err_d            = err_q;
    pend_d           = pend_q || (sync && state_q != IDLE);
    err_d[ERR_OVF]   = err_q[ERR_OVF] | ovf;
    case (state_q)
      IDLE: if (!sync && level >= LVL_TH) state_d = AW;
      AW:   if (AXI_awready) state_d = W;
      W:    if (AXI_wready) begin
        beat_d  = last_beat ? 4'd0 : beat_q + 4'd1;
        state_d = last_beat ? B : W;
      end
      B:    if (AXI_bvalid) begin
        state_d        = IDLE;
        cnt_d          = cnt_q + 32'd1;
        err_d[ERR_SLV] = err_q[ERR_SLV] | (AXI_bresp != RESP_OKAY);
        offset_d       = offset_q + BURST_BYTES;
      end
      default: ;
    endcase
    if (flush) begin
      offset_d = '0;
      cnt_d    = '0;
      err_d    = '0;
      pend_d   = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge AXI_clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
    end

  assign AXI_awaddr  = ocm_haddr | {{(32-ocm_width){1'b0}}, offset_q};
  assign AXI_awlen   = LAST_BEAT;
  assign AXI_awsize  = size_enc(DATA_W);
  assign AXI_awburst = BURST_INCR;
  assign AXI_awid    = AXI_ID;
  assign AXI_awlock  = '0;
  assign AXI_awcache = '0;
  assign AXI_awprot  = '0;
  assign AXI_awqos   = '0;
  assign AXI_awvalid = state_q == AW;
  assign AXI_wstrb   = '1;
  assign AXI_wid     = AXI_ID;
  assign AXI_wvalid  = state_q == W;
  assign AXI_wlast   = state_q == W && last_beat;
  assign AXI_bready  = state_q == B;
  assign s2a_cnt     = cnt_q;
  assign s2a_err     = err_q;
  assign s2a_busy    = state_q != IDLE;
  assign bid_unused  = ^AXI_bid;
endmodule

// File: tb/tb_s2a_ring_writer.sv
// tb_s2a_ring_writer: directed checks of the ring writer against hand-computed bursts and a memory scoreboard
module tb_s2a_ring_writer;
  localparam logic [31:0] BASE = 32'hfffc0000;
  logic clk = 0, rst = 1, sync = 0, ien = 0;
  logic [31:0] sin = 0;
  always #5 clk = ~clk;

  logic [31:0] a_awaddr, a_wdata, a_cnt;
  logic [3:0]  a_awlen, a_awcache, a_awqos, a_wstrb;
  logic [2:0]  a_awsize, a_awprot;
  logic [1:0]  a_awburst, a_awlock, a_err, a_bresp;
  logic [5:0]  a_awid, a_wid;
  logic        a_awvalid, a_wlast, a_wvalid, a_bready, a_busy, a_bvalid;
  logic        aw_en = 1, w_en = 1;

  s2a_ring_writer dut_a (
    .AXI_clk(clk), .rst(rst), .sync(sync), .Sin(sin), .Ien(ien),
    .AXI_awaddr(a_awaddr), .AXI_awlen(a_awlen), .AXI_awsize(a_awsize), .AXI_awburst(a_awburst),
    .AXI_awid(a_awid), .AXI_awlock(a_awlock), .AXI_awcache(a_awcache), .AXI_awprot(a_awprot),
    .AXI_awqos(a_awqos), .AXI_awvalid(a_awvalid), .AXI_awready(aw_en),
    .AXI_wdata(a_wdata), .AXI_wstrb(a_wstrb), .AXI_wid(a_wid), .AXI_wlast(a_wlast),
    .AXI_wvalid(a_wvalid), .AXI_wready(w_en),
    .AXI_bid(6'h3f), .AXI_bresp(a_bresp), .AXI_bvalid(a_bvalid), .AXI_bready(a_bready),
    .s2a_cnt(a_cnt), .s2a_err(a_err), .s2a_busy(a_busy)
  );

  logic [31:0] b_awaddr, b_cnt;
  logic [63:0] b_wdata, sin_b = 0;
  logic [7:0]  b_wstrb;
  logic [3:0]  b_awlen, b_awcache, b_awqos;
  logic [2:0]  b_awsize, b_awprot;
  logic [1:0]  b_awburst, b_awlock, b_err;
  logic [5:0]  b_awid, b_wid;
  logic        b_awvalid, b_wlast, b_wvalid, b_bready, b_busy, ien_b = 0;
  logic        b_awr = 0, b_wr = 0, b_bv, b_aw_open, b_pend;
  logic [31:0] b_wa;
  logic [63:0] memb [128];
  int          b_viol = 0;

  s2a_ring_writer #(.DATA_W(64), .BURST_LEN(4)) dut_b (
    .AXI_clk(clk), .rst(rst), .sync(1'b0), .Sin(sin_b), .Ien(ien_b),
    .AXI_awaddr(b_awaddr), .AXI_awlen(b_awlen), .AXI_awsize(b_awsize), .AXI_awburst(b_awburst),
    .AXI_awid(b_awid), .AXI_awlock(b_awlock), .AXI_awcache(b_awcache), .AXI_awprot(b_awprot),
    .AXI_awqos(b_awqos), .AXI_awvalid(b_awvalid), .AXI_awready(b_awr),
    .AXI_wdata(b_wdata), .AXI_wstrb(b_wstrb), .AXI_wid(b_wid), .AXI_wlast(b_wlast),
    .AXI_wvalid(b_wvalid), .AXI_wready(b_wr),
    .AXI_bid(6'h3f), .AXI_bresp(2'b00), .AXI_bvalid(b_bv), .AXI_bready(b_bready),
    .s2a_cnt(b_cnt), .s2a_err(b_err), .s2a_busy(b_busy)
  );

  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // slave A: always-ready by default, logs addresses and beats, answers B one cycle after wlast
  logic [31:0] aw_log[$], w_log[$];
  int bad_burst = -1, bcnt, wl_err = 0;
  assign a_bresp = (bcnt == bad_burst) ? 2'b10 : 2'b00;
  always @(posedge clk or posedge rst)
    if (rst) begin
      a_bvalid <= 0;
      bcnt     <= 0;
    end else begin
      if (a_awvalid && aw_en) aw_log.push_back(a_awaddr);
      if (a_wvalid && w_en) begin
        if (a_wlast != (w_log.size() % 16 == 15)) wl_err <= wl_err + 1;
        w_log.push_back(a_wdata);
      end
      if (a_bvalid && a_bready) begin
        a_bvalid <= 0;
        bcnt     <= bcnt + 1;
      end else if (a_wvalid && w_en && a_wlast) a_bvalid <= 1;
    end

  // slave B: random stalls on every channel, writes into a word-indexed memory
  always @(posedge clk or posedge rst)
    if (rst) begin
      b_bv      <= 0;
      b_aw_open <= 0;
      b_pend    <= 0;
    end else begin
      b_awr <= 1'($urandom_range(0, 1));
      b_wr  <= 1'($urandom_range(0, 1));
      if (b_wvalid && !b_aw_open) b_viol <= b_viol + 1;
      if (b_awvalid && b_awr) begin
        b_aw_open <= 1;
        b_wa      <= b_awaddr;
      end
      if (b_wvalid && b_wr) begin
        memb[7'((b_wa - BASE) >> 3)] <= b_wdata;
        b_wa <= b_wa + 32'd8;
        if (b_wlast) begin
          b_aw_open <= 0;
          b_pend    <= 1;
        end
      end
      if (b_bv && b_bready) b_bv <= 0;
      else if (b_pend && $urandom_range(0, 2) == 0) begin
        b_bv   <= 1;
        b_pend <= 0;
      end
    end

  function automatic logic [63:0] samp(input int i);
    return {32'hc0de0000 | 32'(i), 32'(i) ^ 32'h5a5a5a5a};
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst = 1; ien = 0; sync = 0; aw_en = 1; w_en = 1; bad_burst = -1;
    @(negedge clk);
    @(negedge clk);
    aw_log.delete();
    w_log.delete();
    rst = 0;
  endtask

  task automatic push(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ien = 1; sync = 0; sin = 32'(first + i);
    end
    @(negedge clk);
    ien = 0; sync = 0;
  endtask

  task automatic wait_cnt(input string tag, input int target);
    for (int i = 0; i < 2000 && a_cnt != 32'(target); i++) @(negedge clk);
    check(tag, a_cnt, 32'(target));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bit synced;
    // 1: reset state, constants, single burst 0..15
    do_reset();
    check("rst_ctrl", {a_awvalid, a_wvalid, a_wlast, a_bready, a_busy}, 0);
    check("rst_awaddr", a_awaddr, BASE);
    check("rst_cnt_err", {a_cnt, a_err}, 0);
    check("rst_zero", {a_awlock, a_awcache, a_awprot, a_awqos}, 0);
    check("rst_const", {a_awlen, a_awsize, a_awburst, a_awid, a_wid, a_wstrb}, {4'hf, 3'd2, 2'b01, 6'h3f, 6'h3f, 4'hf});
    push(0, 16);
    check("t1_aw_not_yet", a_awvalid, 0);
    @(negedge clk);
    check("t1_aw_issued", {a_awvalid, a_busy, a_awaddr}, {2'b11, BASE});
    wait_cnt("t1_cnt", 1);
    check("t1_first_burst", {w_log[0], w_log[15], 32'(w_log.size())}, {32'd0, 32'd15, 32'd16});
    // 2: 1024 more bursts; burst 1025 wraps to the ring base
    for (int k = 1; k <= 1024; k++) begin
      push(16 * k, 16);
      repeat (3) @(negedge clk);
    end
    wait_cnt("t2_cnt", 1025);
    check("t2_aw_count", aw_log.size(), 1025);
    check("t2_addr_last_before_wrap", aw_log[1023], BASE + 32'hffc0);
    check("t2_addr_wrap", aw_log[1024], BASE);
    check("t2_err", a_err, 0);
    bad = 0;
    foreach (w_log[i]) if (w_log[i] != 32'(i)) bad++;
    check("t2_data", bad, 0);
    check("t2_wlast_pos", wl_err, 0);
    // 3: stalled slave, 40 samples into a 32-deep FIFO
    do_reset();
    aw_en = 0; w_en = 0;
    push(0, 40);
    check("t3_ovf", a_err, 2'b01);
    check("t3_aw_hold", a_awvalid, 1);
    aw_en = 1; w_en = 1;
    wait_cnt("t3_cnt2", 2);
    push(40, 16);
    wait_cnt("t3_cnt3", 3);
    check("t3_beats", w_log.size(), 48);
    bad = 0;
    for (int i = 0; i < 48; i++) if (w_log[i] != 32'(i < 32 ? i : i + 8)) bad++;
    check("t3_dropped_only", bad, 0);
    check("t3_ovf_sticky", a_err, 2'b01);
    // 4: sync during beat 5 of the first burst
    do_reset();
    synced = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ien = 1; sin = 32'(i);
      sync = !synced && w_log.size() == 5;
      if (sync) synced = 1;
    end
    @(negedge clk);
    ien = 0; sync = 0;
    check("t4_cnt_after_sync", a_cnt, 0);
    wait_cnt("t4_cnt_new", 1);
    check("t4_aw_count", aw_log.size(), 2);
    check("t4_addr_restart", aw_log[1], BASE);
    check("t4_old_burst", w_log[15], 15);
    check("t4_new_frame", {w_log[16], w_log[31]}, {32'd35, 32'd50});
    check("t4_err", a_err, 0);
    // 4b: sync in IDLE flushes leftovers and keeps the sync-cycle sample
    @(negedge clk);
    ien = 1; sin = 200; sync = 1;
    push(201, 15);
    check("t4b_cnt_clr", a_cnt, 0);
    wait_cnt("t4b_cnt", 1);
    check("t4b_addr", aw_log[2], BASE);
    check("t4b_data", {w_log[32], w_log[47]}, {32'd200, 32'd215});
    // 5: SLVERR on the third burst
    do_reset();
    bad_burst = 2;
    for (int k = 0; k < 2; k++) begin
      push(16 * k, 16);
      repeat (3) @(negedge clk);
    end
    wait_cnt("t5_cnt2", 2);
    check("t5_err_before", a_err, 0);
    for (int k = 2; k < 4; k++) begin
      push(16 * k, 16);
      repeat (3) @(negedge clk);
    end
    wait_cnt("t5_cnt4", 4);
    check("t5_slverr_sticky", a_err, 2'b10);
    // 6: 64-bit, 4-beat instance under random stalls
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      ien_b = 1; sin_b = samp(i);
      @(negedge clk);
      ien_b = 0;
      repeat ($urandom_range(2, 8)) @(negedge clk);
    end
    for (int i = 0; i < 3000 && b_cnt != 32'd20; i++) @(negedge clk);
    check("t6_cnt", b_cnt, 20);
    check("t6_err", b_err, 0);
    check("t6_const", {b_awlen, b_awsize, b_wstrb}, {4'd3, 3'd3, 8'hff});
    check("t6_wvalid_before_aw", b_viol, 0);
    bad = 0;
    for (int i = 0; i < 80; i++) if (memb[i] !== samp(i)) bad++;
    check("t6_mem", bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
